// File: rtl/ccsds123_bit_unpacker_if.sv
// ---------------------------------------------------------------------------
// ccsds123_bit_unpacker_if
// Handshake bundle for the CCSDS-123 bit unpacker.
//   s_axis_* : compressed bitstream words (AXI-Stream style, tlast = image end)
//   cmd_*    : field-length requests
//   out_*    : extracted fields, right-aligned and zero-extended
// Modports:
//   master : the side that produces the stream and commands and consumes fields
//   slave  : the unpacker itself
// ---------------------------------------------------------------------------
interface ccsds123_bit_unpacker_if #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned LEN_W     = 6
);
    logic [BUS_WIDTH-1:0] s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;

    logic [LEN_W-1:0]     cmd_len;
    logic                 cmd_valid;
    logic                 cmd_ready;

    logic [MAX_LEN-1:0]   out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output cmd_len, cmd_valid,
        output out_ready,
        input  s_axis_tready, cmd_ready,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  cmd_len, cmd_valid,
        input  out_ready,
        output s_axis_tready, cmd_ready,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/ccsds123_bit_unpacker.sv
// ---------------------------------------------------------------------------
// ccsds123_bit_unpacker
// Extracts variable-length fields from a CCSDS-123 compressed bitstream.
// Stream bit order: byte lane 0 first, MSB first within each byte.
// A 2*BUS_WIDTH bit buffer holds pending bits, oldest bit at the top.
//
// Ports:
//   clk, areset   : clock, asynchronous active-high reset
//   bus (slave)   : s_axis_* stream in, cmd_* length requests, out_* fields
//   err_len       : sticky, a request had length 0 or > MAX_LEN
//   err_underflow : sticky, a request ran past the end of the tlast word
//   stat_words    : accepted input words (wraps)
//   stat_fields   : delivered output fields (wraps)
//
// Build option: define CCSDS123_UNPACKER_STATS_EN to build the statistics
// counters; otherwise stat_words/stat_fields are tied to zero.
//
// s_axis_tready and cmd_ready are combinational handshake returns.
// ---------------------------------------------------------------------------
module ccsds123_bit_unpacker #(
    parameter int unsigned BUS_WIDTH = 64,
    parameter int unsigned MAX_LEN   = 32,
    parameter int unsigned LEN_W     = 6
) (
    input  logic                         clk,
    input  logic                         areset,
    ccsds123_bit_unpacker_if.slave       bus,
    output logic                         err_len,
    output logic                         err_underflow,
    output logic [31:0]                  stat_words,
    output logic [31:0]                  stat_fields
);
    localparam int unsigned BUF_W  = 2 * BUS_WIDTH;
    localparam int unsigned FILL_W = $clog2(BUF_W + 1);
    localparam int unsigned NBYTES = BUS_WIDTH / 8;

    // Registered state
    logic [BUF_W-1:0]   buf_q,       buf_d;
    logic [FILL_W-1:0]  fill_q,      fill_d;
    logic               held_q,      held_d;
    logic               alive_q;
    logic [MAX_LEN-1:0] out_data_q,  out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q,  out_last_d;
    logic               err_len_q,   err_len_d;
    logic               err_uf_q,    err_uf_d;

    // Combinational helpers
    logic [BUS_WIDTH-1:0] word_ord;
    logic [FILL_W-1:0]    len_ext;
    logic [FILL_W-1:0]    take;
    logic [FILL_W-1:0]    fill_rem;
    logic [BUF_W-1:0]     buf_rem;
    logic                 len_bad;
    logic                 slot_free;
    logic                 s_ready_c;
    logic                 c_ready_c;
    logic                 word_fire;
    logic                 cmd_fire;
    logic                 out_fire;

    // Byte-reverse the word so stream bit 0 (lane 0, bit 7) lands at the MSB
    always_comb begin : byte_order
        word_ord = '0;
        for (int i = 0; i < int'(NBYTES); i++) begin
            word_ord[BUS_WIDTH-1-8*i -: 8] = bus.s_axis_tdata[8*i +: 8];
        end
    end

    // Handshake returns; alive_q keeps both low until the first cycle after reset
    always_comb begin : handshake
        len_ext   = FILL_W'(bus.cmd_len);
        len_bad   = (bus.cmd_len == '0) || (32'(bus.cmd_len) > 32'(MAX_LEN));
        slot_free = !out_valid_q || bus.out_ready;
        s_ready_c = alive_q && !held_q && (fill_q <= FILL_W'(BUS_WIDTH));
        // Illegal lengths consume nothing, so they never wait for buffered data
        c_ready_c = alive_q && slot_free && (len_bad || held_q || (fill_q >= len_ext));
        word_fire = bus.s_axis_tvalid && s_ready_c;
        cmd_fire  = bus.cmd_valid && c_ready_c;
        out_fire  = out_valid_q && bus.out_ready;
    end

    assign bus.s_axis_tready = s_ready_c;
    assign bus.cmd_ready     = c_ready_c;

    // Next-state: consume the requested field first, then append any new word
    always_comb begin : next_state
        buf_d       = buf_q;
        fill_d      = fill_q;
        held_d      = held_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_len_d   = err_len_q;
        err_uf_d    = err_uf_q;
        take        = '0;
        buf_rem     = buf_q;
        fill_rem    = fill_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
        end

        if (cmd_fire) begin
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            out_data_d  = '0;
            if (len_bad) begin
                err_len_d = 1'b1;
            end else begin
                // Bits below fill are always zero, so an underflow pads with zeros
                take       = (len_ext > fill_q) ? fill_q : len_ext;
                out_data_d = MAX_LEN'(buf_q >> (32'(BUF_W) - 32'(len_ext)));
                buf_rem    = buf_q << take;
                fill_rem   = fill_q - take;
                if (held_q && (len_ext >= fill_q)) begin
                    out_last_d = 1'b1;
                    if (len_ext > fill_q) begin
                        err_uf_d = 1'b1;
                    end
                end
            end
        end

        if (out_last_d && cmd_fire) begin
            // End of image: drop whatever is left of the tlast word
            buf_d  = '0;
            fill_d = '0;
            held_d = 1'b0;
        end else begin
            buf_d  = buf_rem;
            fill_d = fill_rem;
            if (word_fire) begin
                buf_d  = buf_rem | ({word_ord, {BUS_WIDTH{1'b0}}} >> fill_rem);
                fill_d = fill_rem + FILL_W'(BUS_WIDTH);
                held_d = bus.s_axis_tlast;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge areset) begin : state_reg
        if (areset) begin
            buf_q       <= '0;
            fill_q      <= '0;
            held_q      <= 1'b0;
            alive_q     <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_len_q   <= 1'b0;
            err_uf_q    <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            held_q      <= held_d;
            alive_q     <= 1'b1;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_len_q   <= err_len_d;
            err_uf_q    <= err_uf_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign err_len       = err_len_q;
    assign err_underflow = err_uf_q;

`ifdef CCSDS123_UNPACKER_STATS_EN
    logic [31:0] stat_words_q,  stat_words_d;
    logic [31:0] stat_fields_q, stat_fields_d;

    // Free-running wrap-around event counters
    always_comb begin : stats_next
        stat_words_d  = stat_words_q;
        stat_fields_d = stat_fields_q;
        if (word_fire) begin
            stat_words_d = stat_words_q + 32'd1;
        end
        if (out_fire) begin
            stat_fields_d = stat_fields_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge areset) begin : stats_reg
        if (areset) begin
            stat_words_q  <= '0;
            stat_fields_q <= '0;
        end else begin
            stat_words_q  <= stat_words_d;
            stat_fields_q <= stat_fields_d;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_fields = stat_fields_q;
`else
    assign stat_words  = '0;
    assign stat_fields = '0;
`endif

endmodule

// File: tb/tb_ccsds123_bit_unpacker.sv
// ---------------------------------------------------------------------------
// tb_ccsds123_bit_unpacker
// Directed bench for ccsds123_bit_unpacker (BUS_WIDTH=64, MAX_LEN=32).
// A bit-queue model predicts every output each cycle; directed sequences
// also pin hand-computed field values.
// ---------------------------------------------------------------------------
module tb_ccsds123_bit_unpacker;
    localparam int unsigned BW = 64;
    localparam int unsigned ML = 32;
    localparam int unsigned LW = 6;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        err_len;
    logic        err_underflow;
    logic [31:0] stat_words;
    logic [31:0] stat_fields;

    ccsds123_bit_unpacker_if #(.BUS_WIDTH(BW), .MAX_LEN(ML), .LEN_W(LW)) bus ();

    ccsds123_bit_unpacker #(.BUS_WIDTH(BW), .MAX_LEN(ML), .LEN_W(LW)) dut (
        .clk           (clk),
        .areset        (areset),
        .bus           (bus),
        .err_len       (err_len),
        .err_underflow (err_underflow),
        .stat_words    (stat_words),
        .stat_fields   (stat_fields)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural model: a queue of stream bits ----------------
    bit          mq[$];
    bit          m_held   = 1'b0;
    bit          m_alive  = 1'b0;
    bit          m_valid  = 1'b0;
    bit          m_last   = 1'b0;
    bit          m_errl   = 1'b0;
    bit          m_erru   = 1'b0;
    logic [31:0] m_data   = '0;
    logic [31:0] m_words  = '0;
    logic [31:0] m_fields = '0;

    function automatic bit m_sready();
        return m_alive && !m_held && (mq.size() <= int'(BW));
    endfunction

    function automatic bit m_cready();
        int len;
        bit bad;
        len = int'(bus.cmd_len);
        bad = (len == 0) || (len > int'(ML));
        return m_alive && (!m_valid || bus.out_ready) && (bad || m_held || mq.size() >= len);
    endfunction

    always @(posedge clk or posedge areset) begin
        if (areset) begin
            mq.delete();
            m_held = 0; m_alive = 0; m_valid = 0; m_last = 0;
            m_errl = 0; m_erru = 0; m_data = '0; m_words = '0; m_fields = '0;
        end else begin
            bit wfire, cfire, ofire;
            logic [63:0] w;
            wfire = bus.s_axis_tvalid && m_sready();
            cfire = bus.cmd_valid && m_cready();
            ofire = m_valid && bus.out_ready;
            w     = bus.s_axis_tdata;
            if (ofire) begin m_fields = m_fields + 1; m_valid = 0; end
            if (wfire) m_words = m_words + 1;
            if (cfire) begin
                int len, avail, n;
                logic [63:0] v;
                len   = int'(bus.cmd_len);
                avail = mq.size();
                m_valid = 1;
                m_last  = 0;
                if (len == 0 || len > int'(ML)) begin
                    m_data = '0;
                    m_errl = 1;
                end else begin
                    n = (len < avail) ? len : avail;
                    v = '0;
                    for (int i = 0; i < len; i++) v = {v[62:0], (i < n) ? mq[i] : 1'b0};
                    for (int i = 0; i < n; i++) void'(mq.pop_front());
                    m_data = v[31:0];
                    if (m_held && len >= avail) begin
                        m_last = 1;
                        if (len > avail) m_erru = 1;
                        mq.delete();
                        m_held = 0;
                    end
                end
            end
            if (wfire) begin
                for (int k = 0; k < int'(BW); k++) mq.push_back(w[8*(k/8) + 7 - (k%8)]);
                m_held = bus.s_axis_tlast;
            end
            m_alive = 1;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_data", 64'(bus.out_data), 64'(m_data));
            chk("out_last", 64'(bus.out_last), 64'(m_last));
        end
        chk("err_len", 64'(err_len), 64'(m_errl));
        chk("err_underflow", 64'(err_underflow), 64'(m_erru));
        chk("s_axis_tready", 64'(bus.s_axis_tready), 64'(m_sready()));
        chk("cmd_ready", 64'(bus.cmd_ready), 64'(m_cready()));
`ifdef CCSDS123_UNPACKER_STATS_EN
        chk("stat_words", 64'(stat_words), 64'(m_words));
        chk("stat_fields", 64'(stat_fields), 64'(m_fields));
`else
        chk("stat_words", 64'(stat_words), 64'd0);
        chk("stat_fields", 64'(stat_fields), 64'd0);
`endif
    end

    // ---------------- stimulus helpers (entered 1 time unit after a rising edge) ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.s_axis_tdata = '0;
        bus.cmd_valid = 0; bus.cmd_len = '0; bus.out_ready = 1;
        areset = 1; #2;
        chk("rst_tready", 64'(bus.s_axis_tready), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_err_len", 64'(err_len), 64'd0);
        chk("rst_err_uf", 64'(err_underflow), 64'd0);
        chk("rst_stat_words", 64'(stat_words), 64'd0);
        chk("rst_stat_fields", 64'(stat_fields), 64'd0);
        tick(); tick();
        areset = 0; #1;
        chk("rst_release_tready_low", 64'(bus.s_axis_tready), 64'd0);
        @(posedge clk); #1;
        chk("rst_release_tready_high", 64'(bus.s_axis_tready), 64'd1);
    endtask

    task automatic send_word(input logic [63:0] d, input logic last);
        int n;
        n = 0;
        bus.s_axis_tdata = d; bus.s_axis_tlast = last; bus.s_axis_tvalid = 1; #1;
        while (!bus.s_axis_tready && n < 100) begin tick(); n++; end
        chk("word_accept_wait", 64'(n < 100), 64'd1);
        if (n < 100) tick();
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0;
    endtask

    // Returns one time unit after the accepting edge, when out_valid must be up
    task automatic issue(input int len);
        int n;
        n = 0;
        bus.cmd_len = LW'(len); bus.cmd_valid = 1; #1;
        while (!bus.cmd_ready && n < 100) begin tick(); n++; end
        chk("cmd_accept_wait", 64'(n < 100), 64'd1);
        if (n < 100) tick();
        bus.cmd_valid = 0;
    endtask

    task automatic expect_field(input string name, input logic [31:0] data, input logic last);
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_data"}, 64'(bus.out_data), 64'(data));
        chk({name, "_last"}, 64'(bus.out_last), 64'(last));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.s_axis_tdata = '0;
        bus.cmd_valid = 0; bus.cmd_len = '0; bus.out_ready = 1;
        tick();

        // Two 4-bit fields from lane 0 = 0xA5
        do_reset();
        send_word(64'h00000000000000A5, 1'b0);
        issue(4);  expect_field("nib0", 32'hA, 1'b0);
        issue(4);  expect_field("nib1", 32'h5, 1'b0);

        // Two words, tlast on the second, four 32-bit fields
        do_reset();
        send_word(64'h8877665544332211, 1'b0);
        send_word(64'h00FFEEDDCCBBAA99, 1'b1);
        issue(32); expect_field("w32_0", 32'h11223344, 1'b0);
        issue(32); expect_field("w32_1", 32'h55667788, 1'b0);
        issue(32); expect_field("w32_2", 32'h99AABBCC, 1'b0);
        issue(32); expect_field("w32_3", 32'hDDEEFF00, 1'b1);
        chk("w32_no_underflow", 64'(err_underflow), 64'd0);
        tick();
        chk("w32_tready_after_last", 64'(bus.s_axis_tready), 64'd1);

        // Underflow past the tlast word: 30 + 30 + 8 bits from 64
        do_reset();
        send_word(64'hF5DEBC9A78563412, 1'b1);
        issue(30); expect_field("uf_0", 32'h048D159E, 1'b0);
        issue(30); expect_field("uf_1", 32'h09ABCDEF, 1'b0);
        issue(8);  expect_field("uf_2", 32'h00000050, 1'b1);
        chk("uf_err_underflow", 64'(err_underflow), 64'd1);
        chk("uf_err_len", 64'(err_len), 64'd0);

        // Illegal lengths consume nothing and set err_len
        do_reset();
        send_word(64'h00000000000000A5, 1'b0);
        issue(0);  expect_field("len0", 32'h0, 1'b0);
        chk("len0_err_len", 64'(err_len), 64'd1);
        issue(33); expect_field("len33", 32'h0, 1'b0);
        issue(8);  expect_field("len_after_bad", 32'hA5, 1'b0);
        chk("len_err_sticky", 64'(err_len), 64'd1);

        // Backpressure on the output
        do_reset();
        send_word(64'h0123456789ABCDEF, 1'b0);
        send_word(64'h1122334455667788, 1'b0);
        chk("bp_full_tready", 64'(bus.s_axis_tready), 64'd0);
        bus.out_ready = 0;
        issue(8);  expect_field("bp_hold", 32'hEF, 1'b0);
        bus.cmd_len = LW'(8);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_field("bp_stable", 32'hEF, 1'b0);
            chk("bp_cmd_ready", 64'(bus.cmd_ready), 64'd0);
            chk("bp_tready", 64'(bus.s_axis_tready), 64'd0);
        end
        bus.out_ready = 1;
        tick();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);
        issue(8);  expect_field("bp_next", 32'hCD, 1'b0);

        // Word accept and field consume in the same cycle
        do_reset();
        send_word(64'h8877665544332211, 1'b0);
        fork
            send_word(64'h00FFEEDDCCBBAA99, 1'b0);
            issue(16);
        join
        expect_field("sim_0", 32'h00001122, 1'b0);
        chk("sim_fill112_tready", 64'(bus.s_axis_tready), 64'd0);
        issue(16); expect_field("sim_1", 32'h00003344, 1'b0);
        issue(32); expect_field("sim_2", 32'h55667788, 1'b0);
        issue(32); expect_field("sim_3", 32'h99AABBCC, 1'b0);
        chk("sim_fill32_tready", 64'(bus.s_axis_tready), 64'd1);

        // Reset with 70 bits buffered, then a fresh stream
        do_reset();
        send_word(64'h8877665544332211, 1'b0);
        send_word(64'h00FFEEDDCCBBAA99, 1'b0);
        issue(32); expect_field("pre_rst_0", 32'h11223344, 1'b0);
        issue(26); expect_field("pre_rst_1", 32'h55667788 >> 6, 1'b0);
        do_reset();
        send_word(64'h00000000000000C3, 1'b0);
        issue(8);  expect_field("post_rst", 32'hC3, 1'b0);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ccsds123_bit_unpacker.md
CCSDS123_BIT_UNPACKER -- requirements
Module: ccsds123_bit_unpacker

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, width of input stream words in bits (multiple of 8).
REQ-002 SHALL have parameter MAX_LEN, default 32, largest field length in bits (1..BUS_WIDTH).
REQ-003 SHALL have parameter LEN_W, default 6, width of cmd_len (2^LEN_W > MAX_LEN).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port areset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_axis_tdata  input  BUS_WIDTH  compressed bitstream word.
REQ-007 SHALL have ports s_axis_tvalid  input  1, s_axis_tready  output  1, s_axis_tlast  input  1 (last word of compressed image).
REQ-008 SHALL have ports cmd_len  input  LEN_W, cmd_valid  input  1, cmd_ready  output  1: field-length request.
REQ-009 SHALL have ports out_data  output  MAX_LEN (field right-aligned, zero-extended), out_valid  output  1, out_ready  input  1, out_last  output  1.
REQ-010 SHALL have ports err_len  output  1 (sticky), err_underflow  output  1 (sticky).
REQ-011 SHALL have ports stat_words  output  32, stat_fields  output  32.

Function
REQ-012 Bit order SHALL be: byte lane 0 (tdata[7:0]) first, ascending lanes; within a byte MSB first; first stream bit = tdata[7].
REQ-013 Internal bit buffer SHALL be 2*BUS_WIDTH bits with fill count 0..2*BUS_WIDTH.
REQ-014 s_axis_tready SHALL be 1 when fill <= BUS_WIDTH and no tlast word held; word appended behind existing bits on tvalid&tready.
REQ-015 cmd_ready SHALL be 1 when (out_valid=0 or out_ready=1) and (fill >= cmd_len or tlast word held).
REQ-016 On cmd_valid&cmd_ready, next cycle SHALL assert out_valid with the next cmd_len bits (first bit at out_data[cmd_len-1]); latency exactly 1 cycle.
REQ-017 out_data/out_valid/out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 Word acceptance and field consumption in same cycle SHALL give fill_next = fill + BUS_WIDTH - cmd_len.
REQ-019 cmd_len = 0 or > MAX_LEN SHALL be accepted, consume 0 bits, return out_data=0, set err_len.
REQ-020 out_last SHALL be 1 on the field consuming the final bit of the tlast word; then remaining buffered bits discarded, fill=0, tlast-held cleared.
REQ-021 Request exceeding remaining bits after tlast SHALL return available bits MSB-aligned to the field, zero-padded below, out_last=1, err_underflow=1.
REQ-022 stat_words SHALL count accepted input words, stat_fields count out_valid&out_ready transfers; both wrap at 2^32.

Reset
REQ-023 areset SHALL immediately clear: fill=0, tlast-held=0, s_axis_tready=0, cmd_ready=0, out_valid=0, out_last=0, out_data=0, err_len=0, err_underflow=0, stat_words=0, stat_fields=0.
REQ-024 Reset mid-transfer SHALL discard all buffered bits and any pending output; s_axis_tready rises first cycle after release.

Configuration
REQ-025 Macro CCSDS123_UNPACKER_STATS_EN defined: stat_words/stat_fields count per REQ-022.
REQ-026 Macro CCSDS123_UNPACKER_STATS_EN undefined: counters not built, stat_words and stat_fields tied to 0; all other behaviour identical.

Verification (BUS_WIDTH=64, MAX_LEN=32)
REQ-027 Word tdata=0x...00A5 (lane0=0xA5), two cmd_len=4 -> out_data 0xA then 0x5, each 1 cycle after cmd accept.
REQ-028 Words W0,W1 (W1 tlast), 32-bit requests until 128 bits consumed -> 4 fields, byte-reassembled data matches, out_last only on 4th.
REQ-029 One tlast word, requests 60 then 8 -> second field = 4 real bits in out_data[7:4], zeros [3:0], out_last=1, err_underflow=1.
REQ-030 out_ready held 0 for 10 cycles with out_valid=1 -> out_data stable, cmd_ready=0, input fills to 128 bits then s_axis_tready=0.
REQ-031 cmd_len=0 and cmd_len=33 -> out_data=0, no bits consumed, err_len=1 until reset.
REQ-032 areset pulsed with 70 bits buffered -> all outputs 0; new stream after release decodes from its first bit; stats 0 (or 0 always without macro).
